tea_host_ctrl: RTL

Host-side sequencer that drives the TEA core's pin-level protocol on behalf of a streaming client. It turns valid/ready key and data channels into the core's two-cycle key load (`core_reset` pulse), one-cycle `core_write`, and done-wait sequence. It returns each result on a valid/ready channel and flags a core that never completes. It sits between the bus or stream fabric and one TEA core instance.

---
 rtl/tea_pkg.sv | 29 ++
 rtl/tea_cbc_chain.sv | 43 ++++
 rtl/tea_host_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tea_pkg.sv
// Shared types and constants for the TEA host sequencer.
// CBC chaining is compiled in when TEA_CBC_EN is defined.
package tea_pkg;

    localparam logic [31:0] DELTA           = 32'h9E3779B9;
    localparam int unsigned ROUNDS_DEFAULT  = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 40;
    localparam int unsigned BLK_W           = 64;
    localparam int unsigned KEY_W           = 128;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [2:0] {
        S_NOKEY,
        S_KEY_HI,
        S_KEY_LO,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } tea_state_e;

    typedef struct packed {
        logic [BLK_W-1:0] hi;
        logic [BLK_W-1:0] lo;
    } tea_key_t;

endpackage

// File: rtl/tea_cbc_chain.sv
// CBC chain register with operand pre-XOR and result post-XOR.
// Only instantiated when TEA_CBC_EN is defined.
module tea_cbc_chain
    import tea_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_iv_i,
    input  logic [BLK_W-1:0] iv_i,
    input  logic             blk_load_i,
    input  logic [BLK_W-1:0] din_i,
    input  logic             mode_i,
    input  logic             capture_i,
    input  logic             blk_mode_i,
    input  logic [BLK_W-1:0] core_out_i,
    output logic [BLK_W-1:0] operand_c_o,
    output logic [BLK_W-1:0] result_c_o
);

    logic [BLK_W-1:0] chain_q;
    logic [BLK_W-1:0] din_q;

    // Chain advances only when a result is captured, so a timeout leaves it untouched.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            chain_q <= '0;
            din_q   <= '0;
        end else begin
            if (blk_load_i) begin
                din_q <= din_i;
            end
            if (load_iv_i) begin
                chain_q <= iv_i;
            end else if (capture_i) begin
                chain_q <= (blk_mode_i == MODE_ENC) ? core_out_i : din_q;
            end
        end
    end

    assign operand_c_o = (mode_i == MODE_ENC) ? (din_i ^ chain_q) : din_i;
    assign result_c_o  = (blk_mode_i == MODE_DEC) ? (core_out_i ^ chain_q) : core_out_i;

endmodule

// File: rtl/tea_host_ctrl.sv
// Host-side sequencer for a pin-level TEA core: key load, block issue, done wait, result return.
// Define TEA_CBC_EN to add CBC chaining and the iv_data_i port.
module tea_host_ctrl
    import tea_pkg::*;
#(
    parameter int unsigned ROUNDS  = ROUNDS_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic [KEY_W-1:0] key_data_i,
`ifdef TEA_CBC_EN
    input  logic [BLK_W-1:0] iv_data_i,
`endif
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [BLK_W-1:0] in_data_i,
    input  logic             in_mode_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [BLK_W-1:0] res_data_o,
    output logic             err_o,
    output logic             busy_o,
    output logic [BLK_W-1:0] core_in_o,
    output logic             core_mode_o,
    output logic             core_reset_o,
    output logic             core_write_o,
    input  logic [BLK_W-1:0] core_out_i,
    input  logic             core_done_i
);

    // A core needs ROUNDS+1 cycles after the write, so clamp a too-short timeout.
    localparam int unsigned TMO   = (TIMEOUT > ROUNDS + 1) ? TIMEOUT : ROUNDS + 2;
    localparam int unsigned CNT_W = $clog2(TMO + 1);

    tea_state_e       state_q;
    logic             key_ready_q;
    logic             in_ready_q;
    logic             res_valid_q;
    logic [BLK_W-1:0] res_data_q;
    logic             err_q;
    logic             busy_q;
    logic [BLK_W-1:0] core_in_q;
    logic             mode_q;
    logic             core_reset_q;
    logic             core_write_q;
    logic [BLK_W-1:0] key_lo_q;
    logic [CNT_W-1:0] tmo_cnt_q;

    tea_key_t         key_in;
    logic             key_hs;
    logic             data_hs;
    logic [BLK_W-1:0] operand_c;
    logic [BLK_W-1:0] result_c;

    assign key_in  = key_data_i;
    // Key has priority in IDLE, so the data-side ready must see key_valid this cycle.
    assign in_ready_o = in_ready_q && !key_valid_i;
    assign key_hs     = key_valid_i && key_ready_q;
    assign data_hs    = in_valid_i && in_ready_o;

`ifdef TEA_CBC_EN
    logic capture;
    assign capture = (state_q == S_WAIT) && core_done_i;

    tea_cbc_chain u_chain (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .load_iv_i   (key_hs),
        .iv_i        (iv_data_i),
        .blk_load_i  (data_hs),
        .din_i       (in_data_i),
        .mode_i      (in_mode_i),
        .capture_i   (capture),
        .blk_mode_i  (mode_q),
        .core_out_i  (core_out_i),
        .operand_c_o (operand_c),
        .result_c_o  (result_c)
    );
`else
    assign operand_c = in_data_i;
    assign result_c  = core_out_i;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_NOKEY;
            key_ready_q  <= 1'b1;
            in_ready_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            core_in_q    <= '0;
            mode_q       <= MODE_ENC;
            core_reset_q <= 1'b0;
            core_write_q <= 1'b0;
            key_lo_q     <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            core_reset_q <= 1'b0;
            core_write_q <= 1'b0;
            // key_ready is only high in NOKEY/IDLE, so this covers both entry points
            if (key_hs) begin
                key_lo_q     <= key_in.lo;
                core_in_q    <= key_in.hi;
                core_reset_q <= 1'b1;
                err_q        <= 1'b0;
                key_ready_q  <= 1'b0;
                in_ready_q   <= 1'b0;
                busy_q       <= 1'b1;
                state_q      <= S_KEY_HI;
            end else begin
                case (state_q)
                    S_NOKEY: ;
                    S_KEY_HI: begin
                        core_in_q <= key_lo_q;
                        state_q   <= S_KEY_LO;
                    end
                    S_KEY_LO: begin
                        key_ready_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (data_hs) begin
                            mode_q       <= in_mode_i;
                            core_in_q    <= operand_c;
                            core_write_q <= 1'b1;
                            key_ready_q  <= 1'b0;
                            in_ready_q   <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        tmo_cnt_q <= '0;
                        state_q   <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (core_done_i) begin
                            res_data_q  <= result_c;
                            res_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else if (tmo_cnt_q == CNT_W'(TMO - 1)) begin
                            err_q       <= 1'b1;
                            key_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_NOKEY;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                        end
                    end
                    S_RESP: begin
                        if (res_ready_i) begin
                            res_valid_q <= 1'b0;
                            key_ready_q <= 1'b1;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                    default: begin
                        key_ready_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_NOKEY;
                    end
                endcase
            end
        end
    end

    assign key_ready_o  = key_ready_q;
    assign res_valid_o  = res_valid_q;
    assign res_data_o   = res_data_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign core_in_o    = core_in_q;
    assign core_mode_o  = mode_q;
    assign core_reset_o = core_reset_q;
    assign core_write_o = core_write_q;

endmodule
